// File: rtl/data_sync_multi_s2f.sv
// data_sync_multi_s2f: multi-channel slow-to-fast bus synchroniser with valid/ready handshake, overrun flag and ack toggle
module data_sync_multi_s2f #(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int MODE       = 0
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] Async_bus,
    input  logic [CHANNELS-1:0]       bus_EN,
    input  logic [CHANNELS-1:0]       out_ready,
    input  logic [CHANNELS-1:0]       overrun_clr,
    output logic [CHANNELS*WIDTH-1:0] sync_bus,
    output logic [CHANNELS-1:0]       EN_pulse,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS-1:0]       ack_toggle,
    output logic [CHANNELS-1:0]       overrun
);
    if (NUM_STAGES < 2 || CHANNELS < 1) begin : g_bad_params
        $error("data_sync_multi_s2f: NUM_STAGES must be >= 2 and CHANNELS >= 1");
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [NUM_STAGES-1:0] s;
        logic                  prev, ev, acc, drop;
        logic [WIDTH-1:0]      data_q;
        logic                  pulse_q, valid_q, ack_q, ovr_q;
        always_comb begin
            ev   = (MODE == 1) ? (s[NUM_STAGES-1] ^ prev) : (s[NUM_STAGES-1] & ~prev);
            acc  = ev & (~valid_q | out_ready[c]);
            drop = ev & valid_q & ~out_ready[c];
        end
        // prev resets to 0, so an enable already high at release counts as a fresh event
        always_ff @(posedge CLK) begin
            if (Reset) begin
                s       <= '0;
                prev    <= 1'b0;
                data_q  <= '0;
                pulse_q <= 1'b0;
                valid_q <= 1'b0;
                ack_q   <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                s       <= {s[NUM_STAGES-2:0], bus_EN[c]};
                prev    <= s[NUM_STAGES-1];
                data_q  <= acc ? Async_bus[c*WIDTH +: WIDTH] : data_q;
                pulse_q <= acc;
                valid_q <= acc | (valid_q & ~out_ready[c]);
                ack_q   <= ack_q ^ acc;
                ovr_q   <= drop | (ovr_q & ~overrun_clr[c]);
            end
        end
        assign sync_bus[c*WIDTH +: WIDTH] = data_q;
        assign EN_pulse[c]   = pulse_q;
        assign out_valid[c]  = valid_q;
        assign ack_toggle[c] = ack_q;
        assign overrun[c]    = ovr_q;
    end
endmodule

// File: tb/tb_data_sync_multi_s2f.sv
// tb_data_sync_multi_s2f: directed vector bench for the level (2-stage) and toggle (3-stage) configurations
module tb_data_sync_multi_s2f;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] bus_a = '0;
    logic [3:0]  en_a = '0, rdy_a = '0, clr_a = '0;
    logic [31:0] sync_a;
    logic [3:0]  pulse_a, valid_a, ack_a, ovr_a;
    logic [15:0] bus_b = '0;
    logic [1:0]  en_b = '0, rdy_b = 2'b11, clr_b = '0;
    logic [15:0] sync_b;
    logic [1:0]  pulse_b, valid_b, ack_b, ovr_b;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    data_sync_multi_s2f #(.NUM_STAGES(2), .WIDTH(8), .CHANNELS(4), .MODE(0)) dut_a (
        .CLK(CLK), .Reset(Reset), .Async_bus(bus_a), .bus_EN(en_a), .out_ready(rdy_a),
        .overrun_clr(clr_a), .sync_bus(sync_a), .EN_pulse(pulse_a), .out_valid(valid_a),
        .ack_toggle(ack_a), .overrun(ovr_a));

    data_sync_multi_s2f #(.NUM_STAGES(3), .WIDTH(8), .CHANNELS(2), .MODE(1)) dut_b (
        .CLK(CLK), .Reset(Reset), .Async_bus(bus_b), .bus_EN(en_b), .out_ready(rdy_b),
        .overrun_clr(clr_b), .sync_bus(sync_b), .EN_pulse(pulse_b), .out_valid(valid_b),
        .ack_toggle(ack_b), .overrun(ovr_b));

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       rdy, clr, p, v;
        logic [7:0] q;
        logic       a, o;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic en, input logic [7:0] d, input logic rdy, input logic clr,
                       input logic p, input logic v, input logic [7:0] q, input logic a, input logic o);
        vec_t t;
        t.en = en; t.d = d; t.rdy = rdy; t.clr = clr;
        t.p = p; t.v = v; t.q = q; t.a = a; t.o = o;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset with random inputs on both instances
        for (int i = 0; i < 3; i++) begin
            bus_a = $urandom; en_a = 4'($urandom); rdy_a = 4'($urandom); clr_a = 4'($urandom);
            bus_b = 16'($urandom); en_b = 2'($urandom);
            step();
        end
        chk("rst_sync_a", sync_a, 0);
        chk("rst_flags_a", {pulse_a, valid_a, ack_a, ovr_a}, 0);
        chk("rst_sync_b", {16'd0, sync_b}, 0);
        chk("rst_flags_b", {24'd0, pulse_b, valid_b, ack_b, ovr_b}, 0);
        bus_a = '0; en_a = '0; rdy_a = '0; clr_a = '0; bus_b = '0; en_b = '0;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rel_no_pulse", {28'd0, pulse_a}, 0);
        end

        // channel 0 level-mode vectors: capture, no event on fall, overrun, clear race, back-to-back
        add(1, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1, 0);
        add(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h5A, 0, 0, 0, 1, 8'hA5, 1, 0);
        add(0, 8'h5A, 1, 0, 0, 0, 8'hA5, 1, 0);
        add(1, 8'h01, 0, 0, 0, 0, 8'hA5, 1, 0);
        add(1, 8'h01, 0, 0, 0, 0, 8'hA5, 1, 0);
        add(1, 8'h01, 0, 0, 1, 1, 8'h01, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h02, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h02, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h02, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h02, 0, 0, 0, 1, 8'h01, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 8'h03, 0, 0, 0, 1, 8'h01, 0, 1);
        add(1, 8'h03, 0, 0, 0, 1, 8'h01, 0, 1);
        add(1, 8'h03, 0, 0, 0, 1, 8'h01, 0, 1);
        add(1, 8'h03, 0, 1, 0, 1, 8'h01, 0, 1);
        add(1, 8'h03, 0, 1, 0, 1, 8'h01, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h04, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h04, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h04, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h04, 1, 0, 1, 1, 8'h04, 1, 0);
        add(1, 8'h04, 0, 0, 0, 1, 8'h04, 1, 0);
        foreach (vecs[i]) begin
            en_a[0] = vecs[i].en; bus_a[7:0] = vecs[i].d; rdy_a[0] = vecs[i].rdy; clr_a[0] = vecs[i].clr;
            step();
            chk($sformatf("v%0d_pulse", i), {31'd0, pulse_a[0]}, {31'd0, vecs[i].p});
            chk($sformatf("v%0d_valid", i), {31'd0, valid_a[0]}, {31'd0, vecs[i].v});
            chk($sformatf("v%0d_data", i), {24'd0, sync_a[7:0]}, {24'd0, vecs[i].q});
            chk($sformatf("v%0d_ack", i), {31'd0, ack_a[0]}, {31'd0, vecs[i].a});
            chk($sformatf("v%0d_ovr", i), {31'd0, ovr_a[0]}, {31'd0, vecs[i].o});
            chk($sformatf("v%0d_other_pulse", i), {29'd0, pulse_a[3:1]}, 0);
        end

        // reset one cycle after the sampling edge of channel 1
        en_a = 4'b0010; bus_a[15:8] = 8'h77; rdy_a = '0; clr_a = '0;
        step();
        Reset = 1'b1;
        step();
        chk("mid_rst_pulse", {28'd0, pulse_a}, 0);
        chk("mid_rst_data", {24'd0, sync_a[15:8]}, 0);
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("after_rst_pulse%0d", k), {28'd0, pulse_a}, (k == 3) ? 32'h2 : 32'h0);
        end
        chk("after_rst_data", {24'd0, sync_a[15:8]}, 32'h77);
        chk("after_rst_valid_ack", {24'd0, valid_a, ack_a}, 32'h22);

        // toggle mode, three stages, channel 1
        for (int t = 0; t < 3; t++) begin
            bus_b[15:8] = 8'h11 * 8'(t + 1);
            en_b[1] = ~en_b[1];
            for (int k = 0; k <= 4; k++) begin
                step();
                chk($sformatf("tog%0d_pulse%0d", t, k), {30'd0, pulse_b}, (k == 3) ? 32'h2 : 32'h0);
            end
            chk($sformatf("tog%0d_data", t), {24'd0, sync_b[15:8]}, 32'(8'h11 * 8'(t + 1)));
        end
        chk("tog_ack", {31'd0, ack_b[1]}, 1);
        chk("tog_ovr", {30'd0, ovr_b}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
